// File: rtl/morph_frame_sched_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Package     : morph_pkg
//  Description : Shared encodings for the morphology frame scheduler.
//                Holds the mode and operator-select codes, the scheduler
//                state type and the mode-to-select mapping function.
//  Revision    : 1.0  initial release
// ============================================================================
package morph_pkg;

  // Chain mode requests from the control plane
  localparam logic [2:0] MODE_BYP   = 3'd0;
  localparam logic [2:0] MODE_ERO   = 3'd1;
  localparam logic [2:0] MODE_DIL   = 3'd2;
  localparam logic [2:0] MODE_OPEN  = 3'd3;
  localparam logic [2:0] MODE_CLOSE = 3'd4;

  // Per-stage operator selects
  localparam logic [1:0] SEL_BYP = 2'b00;
  localparam logic [1:0] SEL_ERO = 2'b01;
  localparam logic [1:0] SEL_DIL = 2'b10;

  // Scheduler states: IDLE waits for the first frame boundary after reset,
  // GAP is the vertical blanking interval, FRAME is an active frame.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GAP   = 2'd1,
    ST_FRAME = 2'd2
  } state_t;

  // Modes 0..4 are legal; everything above is rejected
  function automatic logic mode_legal(input logic [2:0] mode);
    return (mode <= MODE_CLOSE);
  endfunction

  // Returns {stg0_sel, stg1_sel}; illegal modes fall back to full bypass
  function automatic logic [3:0] mode2sel(input logic [2:0] mode);
    logic [3:0] sel;
    case (mode)
      MODE_ERO:   sel = {SEL_ERO, SEL_BYP};
      MODE_DIL:   sel = {SEL_DIL, SEL_BYP};
      MODE_OPEN:  sel = {SEL_ERO, SEL_DIL};
      MODE_CLOSE: sel = {SEL_DIL, SEL_ERO};
      default:    sel = {SEL_BYP, SEL_BYP};
    endcase
    return sel;
  endfunction

endpackage : morph_pkg
`default_nettype wire

// File: rtl/morph_frame_sched_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Interface   : morph_frame_sched_if
//  Description : Video tap, control-plane request channel and chain-control
//                outputs of the morphology frame scheduler.
//                master = control plane / video source, slave = scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
interface morph_frame_sched_if #(
  parameter int FCW = 16
);

  logic           pre_vs;
  logic           pre_clken;
  logic [2:0]     cfg_mode;
  logic           cfg_valid;
  logic           cfg_ready;
  logic           cfg_err;
  logic [1:0]     stg0_sel;
  logic [1:0]     stg1_sel;
  logic [2:0]     mode_cur;
  logic           out_blank;
  logic [FCW-1:0] frame_cnt;
  logic           tmo_err;

  modport master (
    output pre_vs, pre_clken, cfg_mode, cfg_valid,
    input  cfg_ready, cfg_err, stg0_sel, stg1_sel, mode_cur,
           out_blank, frame_cnt, tmo_err
  );

  modport slave (
    input  pre_vs, pre_clken, cfg_mode, cfg_valid,
    output cfg_ready, cfg_err, stg0_sel, stg1_sel, mode_cur,
           out_blank, frame_cnt, tmo_err
  );

endinterface : morph_frame_sched_if
`default_nettype wire

// File: rtl/morph_frame_sched_vs_edge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : morph_vs_edge
//  Description : Registers the frame-valid tap and produces single-cycle
//                start-of-frame and end-of-frame pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module morph_vs_edge (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic vs,
  output logic      sof,
  output logic      eof
);

  logic vs_d;
  logic vs_q;

  // Next value of the delayed frame-valid
  always_comb begin
    vs_d = vs;
  end

  // Delay register; cleared by reset so a frame in flight shows up as a start
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q <= 1'b0;
    end else begin
      vs_q <= vs_d;
    end
  end

  assign sof = vs & ~vs_q;
  assign eof = ~vs & vs_q;

endmodule : morph_vs_edge
`default_nettype wire

// File: rtl/morph_frame_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : morph_frame_sched
//  Description : Per-frame scheduler for the two-stage binary morphology
//                chain. Mode requests are held and applied only when a frame
//                ends, output is blanked for a number of frames after a real
//                mode change, completed frames are counted and stalled frames
//                are flagged.
//  Revision    : 1.0  initial release
// ============================================================================
module morph_frame_sched
  import morph_pkg::*;
#(
  parameter int         SETTLE_FRM = 2,
  parameter int         FCW        = 16,
  parameter int         TMO_W      = 24,
  parameter logic [2:0] RST_MODE   = 3'd3
) (
  input  wire logic           clk,
  input  wire logic           rst,
  morph_frame_sched_if.slave  bus
);

  localparam int             SETW        = (SETTLE_FRM > 0) ? $clog2(SETTLE_FRM + 1) : 1;
  localparam logic [SETW-1:0] SETTLE_INIT = SETW'(SETTLE_FRM);
  localparam logic [SETW-1:0] SET_ONE     = 1;
  localparam logic [FCW-1:0]  FCNT_ONE    = 1;
  localparam logic [TMO_W-1:0] TMO_ONE    = 1;
  localparam logic [3:0]      RST_SEL     = mode2sel(RST_MODE);

  // Frame boundary detection
  logic sof;
  logic eof;

  morph_vs_edge u_vs_edge (
    .clk (clk),
    .rst (rst),
    .vs  (bus.pre_vs),
    .sof (sof),
    .eof (eof)
  );

  // State
  state_t          state_q,     state_d;
  logic [2:0]      mode_cur_q,  mode_cur_d;
  logic [1:0]      stg0_sel_q,  stg0_sel_d;
  logic [1:0]      stg1_sel_q,  stg1_sel_d;
  logic            pending_q,   pending_d;
  logic [2:0]      pend_mode_q, pend_mode_d;
  logic            cfg_ready_q, cfg_ready_d;
  logic            cfg_err_q,   cfg_err_d;
  logic            out_blank_q, out_blank_d;
  logic [SETW-1:0] settle_q,    settle_d;
  logic [FCW-1:0]  frame_cnt_q, frame_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q,  tmo_cnt_d;
  logic            tmo_err_q,   tmo_err_d;

  // Event decode
  logic accept;
  logic illegal;
  logic tmo_max;
  logic timeout;
  logic frame_end;
  logic enter_gap;
  logic do_apply;

  // Decode the events of this cycle from current state and inputs
  always_comb begin
    accept    = bus.cfg_valid & cfg_ready_q;
    illegal   = ~mode_legal(bus.cfg_mode);
    tmo_max   = &tmo_cnt_q;
    // An end of frame on the same cycle as the limit counts as a clean end
    timeout   = (state_q == ST_FRAME) & tmo_max & ~eof;
    frame_end = (state_q == ST_FRAME) & eof;
    // IDLE leaves on the first end of frame; that also opens a gap
    enter_gap = frame_end | timeout | ((state_q == ST_IDLE) & eof);
    do_apply  = enter_gap & pending_q;
  end

  // Next-state logic for the scheduler FSM, config holding register and counters
  always_comb begin
    state_d     = state_q;
    mode_cur_d  = mode_cur_q;
    stg0_sel_d  = stg0_sel_q;
    stg1_sel_d  = stg1_sel_q;
    pending_d   = pending_q;
    pend_mode_d = pend_mode_q;
    cfg_ready_d = cfg_ready_q;
    cfg_err_d   = 1'b0;
    out_blank_d = out_blank_q;
    settle_d    = settle_q;
    frame_cnt_d = frame_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    tmo_err_d   = tmo_err_q;

    case (state_q)
      ST_IDLE:  if (eof)             state_d = ST_GAP;
      ST_GAP:   if (sof)             state_d = ST_FRAME;
      ST_FRAME: if (eof || timeout)  state_d = ST_GAP;
      default:                       state_d = ST_IDLE;
    endcase

    // Stall watchdog: any pixel or a new frame restarts it
    if (sof || bus.pre_clken) begin
      tmo_cnt_d = '0;
    end else if ((state_q == ST_FRAME) && !tmo_max) begin
      tmo_cnt_d = tmo_cnt_q + TMO_ONE;
    end

    // Apply the held request at the frame boundary; re-applying the current
    // mode leaves the chain untouched and needs no settling
    if (do_apply) begin
      mode_cur_d               = pend_mode_q;
      {stg0_sel_d, stg1_sel_d} = mode2sel(pend_mode_q);
      pending_d                = 1'b0;
      cfg_ready_d              = 1'b1;
      if (pend_mode_q != mode_cur_q) begin
        settle_d = SETTLE_INIT;
      end
    end

    // Capture a new request; ready is low while one is held so this never
    // collides with an apply
    if (accept) begin
      pending_d   = 1'b1;
      cfg_ready_d = 1'b0;
      pend_mode_d = illegal ? MODE_BYP : bus.cfg_mode;
      cfg_err_d   = illegal;
      tmo_err_d   = 1'b0;
    end

    if (timeout) begin
      tmo_err_d = 1'b1;
    end

    if (frame_end) begin
      frame_cnt_d = frame_cnt_q + FCNT_ONE;
    end

    // Blanking is decided once per frame at its start and then held
    if (sof) begin
      out_blank_d = (settle_q != '0) || (state_q == ST_IDLE);
      if (settle_q != '0) begin
        settle_d = settle_q - SET_ONE;
      end
    end
  end

  // Scheduler state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_cur_q  <= RST_MODE;
      stg0_sel_q  <= RST_SEL[3:2];
      stg1_sel_q  <= RST_SEL[1:0];
      pending_q   <= 1'b0;
      pend_mode_q <= MODE_BYP;
      cfg_ready_q <= 1'b1;
      cfg_err_q   <= 1'b0;
      out_blank_q <= 1'b1;
      settle_q    <= SETTLE_INIT;
      frame_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      tmo_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_cur_q  <= mode_cur_d;
      stg0_sel_q  <= stg0_sel_d;
      stg1_sel_q  <= stg1_sel_d;
      pending_q   <= pending_d;
      pend_mode_q <= pend_mode_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_err_q   <= cfg_err_d;
      out_blank_q <= out_blank_d;
      settle_q    <= settle_d;
      frame_cnt_q <= frame_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      tmo_err_q   <= tmo_err_d;
    end
  end

  assign bus.cfg_ready = cfg_ready_q;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.stg0_sel  = stg0_sel_q;
  assign bus.stg1_sel  = stg1_sel_q;
  assign bus.mode_cur  = mode_cur_q;
  assign bus.out_blank = out_blank_q;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.tmo_err   = tmo_err_q;

endmodule : morph_frame_sched
`default_nettype wire
